pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS-32 core. It generates the `stall`, `flush` and `nop` controls for the IF/ID pipeline register, the PC-hold control for the fetch stage, and the bubble-insert control for ID/EX. It sequences three events: load-use stalls, taken branch/jump redirects, and multi-cycle divide occupancy. It sits beside the decode stage and watches ID and EX stage fields.

## Interface
Parameters:
- `DIV_CYCLES`, 32: EX-stage divider latency in cycles (≥2).
- `REG_AW`, 5: register-address width.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs`, `id_rt`  in  REG_AW  source registers of the instruction in ID.
- `id_use_rs`, `id_use_rt`  in  1  ID instruction actually reads rs / rt.
- `ex_memread`  in  1  EX instruction is a load.
- `ex_rd`  in  REG_AW  EX destination register.
- `ex_redirect`  in  1  taken branch or jump resolved in EX (single-cycle pulse).
- `ex_div_start`  in  1  divide entered EX this cycle.
- `pc_stall`  out  1  hold PC.
- `ifid_stall`  out  1  hold IF/ID contents.
- `ifid_flush`  out  1  zero IF/ID contents.
- `idex_nop`  out  1  load a bubble into ID/EX.
- `div_busy`  out  1  divider occupying EX.
- `stall_cnt`  out  32  saturating count of stall cycles (feature-gated, see Configuration).

## Operation
States: `RUN`, `DIV_WAIT`.

RUN:
- **Redirect.** If `ex_redirect` is asserted:
  - Assert `ifid_flush=1` and `idex_nop=1`.
  - Keep `pc_stall=0` and `ifid_stall=0`.
  - Redirect has the highest priority. A simultaneous load-use condition is ignored because the ID instruction is squashed.
- **Load-use.** Otherwise, if `ex_memread && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd))`:
  - Assert `pc_stall`, `ifid_stall` and `idex_nop` for that cycle.
  - The bubble clears `ex_memread` on the next cycle, so the stall is exactly one cycle.
- **Divide.** If `ex_div_start` is asserted and `ex_redirect=0`:
  - Next state is `DIV_WAIT`.
  - Load the counter with `DIV_CYCLES-1`.
  - Outputs in the start cycle follow the load-use and redirect rules above.

DIV_WAIT:
- Assert `pc_stall=ifid_stall=idex_nop=1` and `div_busy=1`.
- Decrement the counter each cycle.
- When the counter reaches 0, return to `RUN`. `div_busy` drops in that same cycle.
- `ex_redirect` and `ex_div_start` are ignored in this state, because the EX stage is frozen.
- Load-use detection is suppressed in this state.

Counter rules:
- The divide counter is `$clog2(DIV_CYCLES)` bits wide and never wraps; it stops at 0.
- `ifid_flush` and `ifid_stall` are never both 1.

Reset:
- State is `RUN` and the counter is 0.
- `stall_cnt=0` and `div_busy=0`.
- The combinational outputs evaluate to 0 while `rst=1`.
- Reset asserted mid-divide abandons the divide immediately.

## Timing
- All outputs are combinational from the state register plus the current inputs. They are valid within the same cycle as the hazard, with zero-cycle latency.
- Load-use: stall lasts 1 cycle.
- Redirect: flush lasts 1 cycle.
- Divide: starting with the cycle after `ex_div_start`, `div_busy=1` for exactly `DIV_CYCLES-1` cycles.
- `stall_cnt` increments on the clock edge ending any cycle with `pc_stall=1`, and saturates at `32'hFFFF_FFFF`.

## Configuration
Macro `PIPE_HAZARD_STALL_CNT_EN`:
- **Defined:** `stall_cnt` is a 32-bit register behaving as described under Timing.
- **Undefined:**
  - `stall_cnt` is tied to 0.
  - No counter flops are synthesised.
  - Stall and flush behaviour is unchanged.

## Structure
- A shared package `mips_pkg` holds:
  - the state enum `{RUN, DIV_WAIT}`;
  - the constant `REG_ZERO=5'd0`;
  - the default `DIV_CYCLES`.
- One sub-module, `load_use_detect`: purely combinational comparator producing the load-use hit. It is reused by the forwarding unit.
- FSM, divide counter and `stall_cnt` live in the top module.

## Test plan
- **Load-use hit:** `ex_memread=1`, `ex_rd=8`, `id_rs=8`, `id_use_rs=1` → `pc_stall=ifid_stall=idex_nop=1` for 1 cycle, then all 0; `stall_cnt` goes 0→1.
- **Register-zero exclusion:** `ex_rd=0`, `id_rs=0`, `ex_memread=1` → no stall; `id_use_rt=0` with an rt match → no stall.
- **Redirect beats load-use:** `ex_redirect=1` in the same cycle as a load-use hit → `ifid_flush=1`, `idex_nop=1`, `pc_stall=0`, `ifid_stall=0`.
- **Divide sequencing:** `DIV_CYCLES=4`, pulse `ex_div_start` → `div_busy` high for exactly 3 cycles, then back in `RUN`; an `ex_redirect` inside the window is ignored.
- **Reset mid-divide:** assert `rst` on the second `DIV_WAIT` cycle → all outputs 0 immediately; after release, state `RUN` and `stall_cnt=0`.
- **Saturation (macro on):** preload `stall_cnt` to `32'hFFFF_FFFE` and apply 3 stall cycles → holds at `32'hFFFF_FFFF`. With the macro off → reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-32 pipeline control blocks.
//   state_t        hazard-controller FSM states (RUN, DIV_WAIT)
//   REG_ZERO       architectural register $zero; writes to it never create a hazard
//   DIV_CYCLES_DEF default EX-stage divider latency in cycles
package mips_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundles the ID/EX stage fields watched by the hazard
// controller together with the pipeline controls it returns.
//   master: pipeline side, drives the stage fields and consumes the controls
//   slave : hazard controller, consumes the stage fields and drives the controls
// Signalling: there is no valid/ready handshake here. Every stage field is
// sampled combinationally each cycle, and every control is valid in the same
// cycle as the hazard. ex_redirect and ex_div_start are single-cycle pulses.
// dbg_state exposes the controller FSM state for checkers.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  import mips_pkg::*;

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_redirect;
  logic              ex_div_start;

  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_flush;
  logic              idex_nop;
  logic              div_busy;
  logic [31:0]       stall_cnt;
  state_t            dbg_state;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_rd,
           ex_redirect, ex_div_start,
    input  pc_stall, ifid_stall, ifid_flush, idex_nop, div_busy,
           stall_cnt, dbg_state
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_rd,
           ex_redirect, ex_div_start,
    output pc_stall, ifid_stall, ifid_flush, idex_nop, div_busy,
           stall_cnt, dbg_state
  );

endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: purely combinational load-use comparator. Flags when the
// load currently in EX writes a register that the ID instruction reads.
// Shared with the forwarding unit.
//   memread        EX instruction is a load
//   ex_rd          EX destination register
//   id_rs, id_rt   ID source registers
//   use_rs, use_rt ID instruction really reads rs / rt
//   hit            load-use hazard present
module load_use_detect
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              use_rs,
  input  logic              use_rt,
  output logic              hit
);

  logic rd_live;
  logic rs_match;
  logic rt_match;

  // A load into $zero is discarded by the register file, so it cannot feed ID.
  assign rd_live  = (ex_rd != REG_AW'(REG_ZERO));
  assign rs_match = use_rs && (id_rs == ex_rd);
  assign rt_match = use_rt && (id_rt == ex_rd);
  assign hit      = memread && rd_live && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard controller for the 5-stage MIPS-32 core.
// Produces PC-hold, IF/ID stall/flush and ID/EX bubble controls for load-use
// stalls, taken branch/jump redirects and multi-cycle divide occupancy.
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset
//   hz   pipe_hazard_ctrl_if.slave: ID/EX fields in, pipeline controls out,
//        plus stall_cnt and dbg_state
// Parameters:
//   DIV_CYCLES  EX-stage divider latency in cycles (>= 2)
//   REG_AW      register-address width
// Configuration macro PIPE_HAZARD_STALL_CNT_EN: when defined, stall_cnt is a
// saturating 32-bit count of cycles with pc_stall=1; otherwise it is tied to 0
// and no counter flops exist.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int            CW       = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          lu_hit;
  logic          pc_stall;
  logic          ifid_stall;
  logic          ifid_flush;
  logic          idex_nop;
  logic          div_busy;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .memread (hz.ex_memread),
    .ex_rd   (hz.ex_rd),
    .id_rs   (hz.id_rs),
    .id_rt   (hz.id_rt),
    .use_rs  (hz.id_use_rs),
    .use_rt  (hz.id_use_rt),
    .hit     (lu_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_nop   = 1'b0;
    div_busy   = 1'b0;
    // Outputs are forced low while reset is held; the register reset itself is async.
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (hz.ex_redirect) begin
            // The ID instruction is squashed, so a coincident load-use is moot.
            ifid_flush = 1'b1;
            idex_nop   = 1'b1;
          end else if (lu_hit) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_nop   = 1'b1;
          end
          if (hz.ex_div_start && !hz.ex_redirect) begin
            state_d = DIV_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
        DIV_WAIT: begin
          // EX is frozen: redirect/div_start cannot occur and load-use is moot.
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_nop   = 1'b1;
          div_busy   = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          // Leaving on the edge where the counter reaches 0 gives DIV_CYCLES-1 busy cycles.
          if (cnt_q <= CW'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign hz.pc_stall   = pc_stall;
  assign hz.ifid_stall = ifid_stall;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_nop   = idex_nop;
  assign hz.div_busy   = div_busy;
  assign hz.dbg_state  = state_q;

`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
`else
  assign hz.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: self-checking bench for pipe_hazard_ctrl (DIV_CYCLES=4).
// Directed cases for load-use, $zero exclusion, redirect priority, divide
// sequencing, reset mid-divide and stall_cnt saturation, followed by random
// cycles compared with a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  import mips_pkg::*;

  localparam int DIVC = 4;

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if #(.REG_AW(5)) hz ();

  pipe_hazard_ctrl #(.DIV_CYCLES(DIVC), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [4:0]  exp_q[$];      // {pc_stall, ifid_stall, ifid_flush, idex_nop, div_busy}
  int          busy_left = 0; // model: divide cycles still owed
  logic [31:0] exp_cnt = '0;  // model: stall_cnt

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: outputs decided directly from the rule list.
  function automatic logic [4:0] model_ctl(input logic r, input logic [4:0] rs, rt, rd,
                                           input logic urs, urt, mr, redir);
    logic hit;
    if (r) return 5'b0;
    if (busy_left > 0) return 5'b11011;
    if (redir) return 5'b00110;
    hit = mr && (rd != 5'd0) && ((urs && rs == rd) || (urt && rt == rd));
    return hit ? 5'b11010 : 5'b00000;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic [4:0] rs, rt, rd,
                             input logic urs, urt, mr, redir, dstart);
    logic [4:0] e;
    logic [4:0] got;
    @(posedge clk);
    #1;
    hz.id_rs        = rs;
    hz.id_rt        = rt;
    hz.ex_rd        = rd;
    hz.id_use_rs    = urs;
    hz.id_use_rt    = urt;
    hz.ex_memread   = mr;
    hz.ex_redirect  = redir;
    hz.ex_div_start = dstart;
    exp_q.push_back(model_ctl(rst, rs, rt, rd, urs, urt, mr, redir));
    @(negedge clk);
    e   = exp_q.pop_front();
    got = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_nop, hz.div_busy};
    check("ctl", {27'b0, got}, {27'b0, e});
    check("stall_cnt", hz.stall_cnt, exp_cnt);
    check("state", {31'b0, hz.dbg_state}, {31'b0, (busy_left > 0)});
    check("flush_stall_excl", {31'b0, hz.ifid_flush & hz.ifid_stall}, 32'd0);
    // Advance the model across the coming rising edge.
`ifdef PIPE_HAZARD_STALL_CNT_EN
    if (e[4] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
    if (busy_left > 0) busy_left--;
    else if (dstart && !redir) busy_left = DIVC - 1;
  endtask

  task automatic idle_cycle();
    drive_cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_seen;
    rst = 1'b1;
    hz.id_rs = 5'd8; hz.id_rt = 5'd8; hz.ex_rd = 5'd8;
    hz.id_use_rs = 1'b1; hz.id_use_rt = 1'b1; hz.ex_memread = 1'b1;
    hz.ex_redirect = 1'b0; hz.ex_div_start = 1'b0;
    #2;
    // Reset: hazardous inputs must still give quiet outputs.
    check("rst_ctl", {27'b0, hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_nop, hz.div_busy}, 32'd0);
    check("rst_cnt", hz.stall_cnt, 32'd0);
    check("rst_state", {31'b0, hz.dbg_state}, {31'b0, RUN});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Load-use hit on rs, then clear.
    drive_cycle(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    // $zero exclusion, and rt match ignored when rt is not read.
    drive_cycle(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_cycle(5'd3, 5'd8, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Load-use hit via rt.
    drive_cycle(5'd3, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Redirect beats load-use.
    drive_cycle(5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Divide: busy exactly DIVC-1 cycles; redirect inside the window ignored.
    drive_cycle(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    busy_seen = 0;
    for (int i = 0; i < DIVC + 1; i++) begin
      drive_cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, (i == 1), (i == 0));
      if (hz.div_busy) busy_seen++;
    end
    check("div_busy_len", busy_seen, DIVC - 1);

    // Divide start coinciding with a redirect does not start.
    drive_cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycle();

    // Reset on the second DIV_WAIT cycle.
    drive_cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstmid_ctl", {27'b0, hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_nop, hz.div_busy}, 32'd0);
    check("rstmid_cnt", hz.stall_cnt, 32'd0);
    busy_left = 0;
    exp_cnt   = '0;
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();
    check("rstmid_state", {31'b0, hz.dbg_state}, {31'b0, RUN});

`ifdef PIPE_HAZARD_STALL_CNT_EN
    // Saturation: preload just below the top, then three stall cycles.
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    exp_cnt         = 32'hFFFF_FFFE;
`endif
    for (int i = 0; i < 3; i++)
      drive_cycle(5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycle();
`ifdef PIPE_HAZARD_STALL_CNT_EN
    check("sat_cnt", hz.stall_cnt, 32'hFFFF_FFFF);
`else
    check("cnt_off", hz.stall_cnt, 32'd0);
`endif

    // Random traffic; small register range to make collisions common.
    for (int i = 0; i < 400; i++) begin
      drive_cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 11) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
